// File: rtl/pipe_pkg.sv
// pipe_pkg: shared forwarding selects, memory-wait states and forwarding helper
package pipe_pkg;
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;
    typedef enum logic [1:0] {IDLE, WAIT, ERR} memState_t;
    function automatic logic [1:0] fwdSel(logic wM, logic [4:0] rM, logic wW, logic [4:0] rW, logic [4:0] src);
        return (wM && rM != 5'd0 && rM == src) ? FWD_M :
               (wW && rW != 5'd0 && rW == src) ? FWD_W : FWD_RF;
    endfunction
endpackage

// File: rtl/mem_wait_fsm.sv
// mem_wait_fsm: tracks outstanding data-memory waits, raises memStall and a sticky timeout
module mem_wait_fsm
    import pipe_pkg::*;
#(
    parameter int MAX_WAIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic memReq_M,
    input  logic memReady_M,
    output logic memStall,
    output logic memTimeout
);
    localparam int CW = $clog2(MAX_WAIT + 1);
    memState_t state, stateNext;
    logic [CW-1:0] cnt, cntNext;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        case (state)
            IDLE: if (memReq_M && !memReady_M) begin
                stateNext = WAIT;
                cntNext   = CW'(1);
            end
            WAIT: begin
                cntNext   = memReady_M ? '0 : cnt + CW'(1);
                stateNext = memReady_M ? IDLE : (cntNext == CW'(MAX_WAIT) ? ERR : WAIT);
            end
            default: ;
        endcase
    end
    assign memStall   = (state == IDLE && memReq_M && !memReady_M) || (state == WAIT && !memReady_M) || state == ERR;
    assign memTimeout = state == ERR;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush sequencing, EX forwarding selects and hazard perf counters
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs_D,
    input  logic [4:0]       rt_D,
    input  logic [4:0]       rs_E,
    input  logic [4:0]       rt_E,
    input  logic [4:0]       writeReg_E,
    input  logic [4:0]       writeReg_M,
    input  logic [4:0]       writeReg_W,
    input  logic             regWrite_E,
    input  logic             regWrite_M,
    input  logic             regWrite_W,
    input  logic             memToReg_E,
    input  logic             pcSrc_E,
    input  logic             memReq_M,
    input  logic             memReady_M,
    output logic             stall_F,
    output logic             stall_D,
    output logic             stall_E,
    output logic             stall_M,
    output logic             stall_W,
    output logic             flush_D,
    output logic             flush_E,
    output logic             flush_M,
    output logic             flush_W,
    output logic [1:0]       forwardA_E,
    output logic [1:0]       forwardB_E,
    output logic             memTimeout,
    output logic [CNT_W-1:0] stallCycles,
    output logic [CNT_W-1:0] flushCount
);
    logic memStall, tmo, lu, live, ms, br, luHold;
    mem_wait_fsm #(.MAX_WAIT(MAX_WAIT)) uMemWait (
        .clk        (clk),
        .reset      (reset),
        .memReq_M   (memReq_M),
        .memReady_M (memReady_M),
        .memStall   (memStall),
        .memTimeout (tmo)
    );
    assign lu     = memToReg_E && regWrite_E && writeReg_E != 5'd0 && (writeReg_E == rs_D || writeReg_E == rt_D);
    assign live   = !reset;
    assign ms     = live && memStall;
    assign br     = live && !memStall && pcSrc_E;
    assign luHold = live && !memStall && !pcSrc_E && lu;
    assign stall_F = ms || luHold;
    assign stall_D = ms || luHold;
    assign stall_E = ms;
    assign stall_M = ms;
    assign stall_W = live && tmo;
    assign flush_D = br;
    assign flush_E = br || luHold;
    assign flush_M = 1'b0;
    // Once timed out the writeback buffer is frozen, so it must not also be bubbled
    assign flush_W = ms && !tmo;
    assign memTimeout = live && tmo;
    assign forwardA_E = live ? fwdSel(regWrite_M, writeReg_M, regWrite_W, writeReg_W, rs_E) : FWD_RF;
    assign forwardB_E = live ? fwdSel(regWrite_M, writeReg_M, regWrite_W, writeReg_W, rt_E) : FWD_RF;
    always_ff @(posedge clk) begin
        if (reset) begin
            stallCycles <= '0;
            flushCount  <= '0;
        end else begin
            if (stall_F && !(&stallCycles)) stallCycles <= stallCycles + CNT_W'(1);
            if (br && !(&flushCount)) flushCount <= flushCount + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized checks of hazard_ctrl against a behavioural model
module tb_hazard_ctrl;
    localparam int MW = 4;
    logic clk = 1'b0;
    logic reset;
    logic [4:0] rs_D, rt_D, rs_E, rt_E, writeReg_E, writeReg_M, writeReg_W;
    logic regWrite_E, regWrite_M, regWrite_W, memToReg_E, pcSrc_E, memReq_M, memReady_M;
    logic stall_F, stall_D, stall_E, stall_M, stall_W, flush_D, flush_E, flush_M, flush_W, memTimeout;
    logic [1:0] forwardA_E, forwardB_E;
    logic [31:0] stallCycles, flushCount;
    int tests = 0;
    int fails = 0;
    int mWait = 0;
    bit mTmo = 0;
    longint mSc = 0;
    longint mFc = 0;

    hazard_ctrl #(.MAX_WAIT(MW), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .rs_D(rs_D), .rt_D(rt_D), .rs_E(rs_E), .rt_E(rt_E),
        .writeReg_E(writeReg_E), .writeReg_M(writeReg_M), .writeReg_W(writeReg_W),
        .regWrite_E(regWrite_E), .regWrite_M(regWrite_M), .regWrite_W(regWrite_W),
        .memToReg_E(memToReg_E), .pcSrc_E(pcSrc_E), .memReq_M(memReq_M), .memReady_M(memReady_M),
        .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M), .stall_W(stall_W),
        .flush_D(flush_D), .flush_E(flush_E), .flush_M(flush_M), .flush_W(flush_W),
        .forwardA_E(forwardA_E), .forwardB_E(forwardB_E), .memTimeout(memTimeout),
        .stallCycles(stallCycles), .flushCount(flushCount)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, longint act, longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [1:0] fwdModel(logic [4:0] s);
        if (regWrite_M && writeReg_M != 0 && writeReg_M == s) return 2'b10;
        if (regWrite_W && writeReg_W != 0 && writeReg_W == s) return 2'b01;
        return 2'b00;
    endfunction

    // Model: one pass per cycle on the falling edge, then advance to the post-edge state
    always @(negedge clk) begin : cmp
        bit ms, lu, br, luH;
        logic [12:0] exp, act;
        ms = 0; br = 0; luH = 0; exp = '0;
        if (!reset) begin
            ms  = mTmo || (memReq_M && !memReady_M && mWait == 0) || (mWait > 0 && !memReady_M);
            lu  = memToReg_E && regWrite_E && writeReg_E != 0 && (writeReg_E == rs_D || writeReg_E == rt_D);
            br  = pcSrc_E && !ms;
            luH = lu && !ms && !pcSrc_E;
            exp = {ms || luH, ms || luH, ms, ms, mTmo, br, br || luH, 1'b0, ms && !mTmo,
                   fwdModel(rs_E), fwdModel(rt_E)};
        end
        act = {stall_F, stall_D, stall_E, stall_M, stall_W, flush_D, flush_E, flush_M, flush_W, forwardA_E, forwardB_E};
        chk("outputs", longint'(act), longint'(exp));
        chk("memTimeout", longint'(memTimeout), longint'(!reset && mTmo));
        chk("stallCycles", longint'(stallCycles), mSc);
        chk("flushCount", longint'(flushCount), mFc);
        if (reset) begin
            mWait = 0; mTmo = 0; mSc = 0; mFc = 0;
        end else begin
            if ((ms || luH) && mSc < 64'hFFFF_FFFF) mSc++;
            if (br && mFc < 64'hFFFF_FFFF) mFc++;
            if (!mTmo) begin
                if (mWait == 0) begin
                    if (memReq_M && !memReady_M) mWait = 1;
                end else if (memReady_M) mWait = 0;
                else begin
                    mWait++;
                    if (mWait == MW) mTmo = 1;
                end
            end
        end
    end

    task automatic idle();
        {rs_D, rt_D, rs_E, rt_E, writeReg_E, writeReg_M, writeReg_W} = '0;
        {regWrite_E, regWrite_M, regWrite_W, memToReg_E, pcSrc_E, memReq_M} = '0;
        memReady_M = 1'b1;
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic look();
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        memReq_M = 1'b1; memReady_M = 1'b0; pcSrc_E = 1'b1;
        look();
        chk("rst_stallF", longint'(stall_F), 0);
        chk("rst_flushD", longint'(flush_D), 0);
        tick();
        reset = 1'b0; idle();
        look();
        chk("init_stallCycles", longint'(stallCycles), 0);
        tick();
        memToReg_E = 1; regWrite_E = 1; writeReg_E = 5; rt_D = 5;
        look();
        chk("lu_stall", longint'({stall_F, stall_D, flush_E, flush_D, stall_E}), 5'b11100);
        tick();
        idle();
        look();
        chk("lu_count", longint'(stallCycles), 1);
        tick();
        regWrite_M = 1; regWrite_W = 1; writeReg_M = 3; writeReg_W = 3; rs_E = 3; rt_E = 0;
        look();
        chk("fwdA_M", longint'(forwardA_E), 2);
        chk("fwdB_zero", longint'(forwardB_E), 0);
        tick();
        regWrite_M = 0;
        look();
        chk("fwdA_W", longint'(forwardA_E), 1);
        tick();
        idle();
        memToReg_E = 1; regWrite_E = 1; writeReg_E = 5; rt_D = 5; pcSrc_E = 1;
        look();
        chk("br_flush", longint'({flush_D, flush_E, stall_F}), 3'b110);
        tick();
        idle();
        look();
        chk("br_count", longint'(flushCount), 1);
        tick();
        memReq_M = 1; memReady_M = 0;
        for (int i = 0; i < 3; i++) begin
            look();
            chk("mem_wait", longint'({stall_F, stall_D, stall_E, stall_M, flush_W}), 5'b11111);
            tick();
        end
        memReady_M = 1;
        look();
        chk("mem_release", longint'({stall_F, flush_W}), 0);
        tick();
        idle();
        look();
        chk("mem_count", longint'(stallCycles), 4);
        tick();
        memReq_M = 1; memReady_M = 0;
        for (int i = 0; i < MW; i++) begin
            look();
            chk("pre_timeout", longint'({memTimeout, stall_F}), 2'b01);
            tick();
        end
        look();
        chk("timeout", longint'({memTimeout, stall_W, stall_F}), 3'b111);
        tick();
        memReq_M = 0; memReady_M = 1;
        look();
        chk("err_hold", longint'({stall_F, stall_E, stall_M}), 3'b111);
        tick();
        reset = 1;
        look();
        chk("err_reset", longint'({stall_F, memTimeout, stall_W}), 0);
        tick();
        reset = 0; idle();
        look();
        chk("post_reset_cnt", longint'(stallCycles + flushCount), 0);
        tick();
        memReq_M = 1; memReady_M = 1;
        look();
        chk("idle_ready", longint'(stall_F), 0);
        tick();
        memReady_M = 0;
        look();
        chk("idle_restart", longint'(stall_F), 1);
        for (int n = 0; n < 3000; n++) begin
            tick();
            reset      = $urandom_range(99) < 2;
            rs_D       = 5'($urandom_range(3));
            rt_D       = 5'($urandom_range(3));
            rs_E       = 5'($urandom_range(3));
            rt_E       = 5'($urandom_range(3));
            writeReg_E = 5'($urandom_range(3));
            writeReg_M = 5'($urandom_range(3));
            writeReg_W = 5'($urandom_range(3));
            regWrite_E = 1'($urandom_range(1));
            regWrite_M = 1'($urandom_range(1));
            regWrite_W = 1'($urandom_range(1));
            memToReg_E = 1'($urandom_range(1));
            pcSrc_E    = $urandom_range(3) == 0;
            memReq_M   = 1'($urandom_range(1));
            memReady_M = $urandom_range(9) > 2;
        end
        tick();
        look();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage pipeline (fetch, decode, execute, memory, writeBack).
- Drives the stall/flush pair of every inter-stage pipeBuffer and the EX operand-forwarding selects.
- Contains the memory-wait state machine, with a timeout, that freezes the pipeline while the data memory is not ready. Also contains stall/flush performance counters.
- Sits beside the datapath; all hazard inputs are stage-tagged datapath signals.

Parameters:
- MAX_WAIT, 16, memory-wait cycles allowed before timeout (≥2).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- rs_D  in  5  source register 1 of the instruction in decode.
- rt_D  in  5  source register 2 of the instruction in decode.
- rs_E  in  5  source register 1 in execute.
- rt_E  in  5  source register 2 in execute.
- writeReg_E  in  5  destination register in execute.
- writeReg_M  in  5  destination register in memory.
- writeReg_W  in  5  destination register in writeback.
- regWrite_E  in  1  register-write enable in execute.
- regWrite_M  in  1  register-write enable in memory.
- regWrite_W  in  1  register-write enable in writeback.
- memToReg_E  in  1  instruction in execute is a load.
- pcSrc_E  in  1  branch/jump resolved taken in execute.
- memReq_M  in  1  memory stage is accessing data memory.
- memReady_M  in  1  data memory completes the access this cycle.
- stall_F  out  1  hold the PC.
- stall_D  out  1  hold the buffer at the decode input.
- stall_E  out  1  hold the buffer at the execute input.
- stall_M  out  1  hold the buffer at the memory input.
- stall_W  out  1  hold the buffer at the writeback input.
- flush_D  out  1  clear (bubble) the buffer at the decode input.
- flush_E  out  1  clear the buffer at the execute input.
- flush_M  out  1  clear the buffer at the memory input.
- flush_W  out  1  clear the buffer at the writeback input.
- forwardA_E  out  2  operand A select: 00 = register file, 10 = from M, 01 = from W.
- forwardB_E  out  2  operand B select, same encoding as forwardA_E.
- memTimeout  out  1  sticky memory-timeout error.
- stallCycles  out  CNT_W  number of cycles in which stall_F was 1.
- flushCount  out  CNT_W  number of taken-branch flushes.

Behaviour:
- Stall/flush semantics: a buffer whose stall is 1 holds its contents; a buffer whose flush is 1 loads zero (bubble). Never assert stall and flush on the same buffer in the same cycle.
- While reset = 1:
  - all stall/flush outputs are 0 and forward selects are 00;
  - at the clock edge, state ← IDLE, wait counter ← 0, memTimeout ← 0, both perf counters ← 0.
- Forwarding (combinational, every cycle, including stalled cycles), for forwardA_E using rs_E:
  - 10 if regWrite_M and writeReg_M ≠ 0 and writeReg_M = rs_E;
  - else 01 if regWrite_W and writeReg_W ≠ 0 and writeReg_W = rs_E;
  - else 00.
  - M has priority over W. forwardB_E follows the same rule using rt_E.
- Load-use (lu): memToReg_E and regWrite_E and writeReg_E ≠ 0 and (writeReg_E = rs_D or writeReg_E = rt_D).
- Memory FSM, states IDLE / WAIT / ERR:
  - memStall = (IDLE and memReq_M and !memReady_M) or (WAIT and !memReady_M) or ERR.
  - IDLE → WAIT when memReq_M and !memReady_M; wait counter ← 1.
  - WAIT → IDLE when memReady_M; that cycle is not stalled and counter ← 0.
  - In WAIT with !memReady_M: counter increments. When counter = MAX_WAIT, go to ERR.
  - ERR: memTimeout = 1; all pipeline stalls held at 1 until reset.
- Output priority:
  - memStall: stall_F = stall_D = stall_E = stall_M = 1, flush_W = 1; all other flushes 0. A pending pcSrc_E or lu is deferred; it is naturally re-evaluated when the stall releases, because the E instruction is held.
  - else pcSrc_E: flush_D = 1, flush_E = 1; no stalls. Any lu condition is discarded, since the D instruction is squashed.
  - else lu: stall_F = 1, stall_D = 1, flush_E = 1.
  - else: all outputs 0.
- stall_W is 0 except in ERR, where it is 1.
- flush_M is reserved and tied to 0.
- Counters: stallCycles increments when stall_F = 1; flushCount increments when flush_D is caused by pcSrc_E. Both saturate at all-ones; they do not wrap.
- Reset mid-WAIT or in ERR: returns to IDLE at the next edge; outputs go to 0 in the reset cycle.

Decomposition:
- Shared package (pipe_pkg): forward-select constants FWD_RF = 00, FWD_W = 01, FWD_M = 10, and the FSM state enum {IDLE, WAIT, ERR}.
- One natural sub-module: mem_wait_fsm, containing the state register, wait counter and timeout, and producing memStall and memTimeout.
- Forwarding, priority logic and counters stay in the top level.

Test Plan:
- lw r5 in E (memToReg_E = 1, writeReg_E = 5) with rt_D = 5 → stall_F = stall_D = flush_E = 1 for one cycle; stallCycles = 1.
- regWrite_M = regWrite_W = 1, writeReg_M = writeReg_W = 3, rs_E = 3, rt_E = 0 → forwardA_E = 10, forwardB_E = 00. Then drop regWrite_M → forwardA_E = 01.
- pcSrc_E = 1 in the same cycle as lu → flush_D = flush_E = 1, stall_F = 0; flushCount = 1.
- memReq_M = 1 with memReady_M low for 3 cycles then high → stall_F..stall_M = 1 and flush_W = 1 for exactly 3 cycles; released in the ready cycle.
- MAX_WAIT = 4, memReady_M held low → memTimeout = 1 after cycle 4, all stalls remain 1. Assert reset for one cycle → all outputs 0, counters 0, FSM back in IDLE.
